// File: rtl/parity_pkg.sv
// ============================================================================
// Module      : parity_pkg
// Description : Shared constants and helpers for the lane-parity stream block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    // Widest lane the lane_xor helper can reduce.
    localparam int   MAX_LANE_W = 64;

    function automatic logic lane_xor(input logic [MAX_LANE_W-1:0] data,
                                      input int                    width);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_LANE_W; i++) begin
            if (i < width) begin
                r = r ^ data[i];
            end
        end
        return r;
    endfunction

    function automatic bit cfg_ok(input int data_width, input int lanes);
        return (lanes > 0) && (data_width % lanes == 0) &&
               (data_width / lanes >= 1) && (data_width / lanes <= MAX_LANE_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/parity_lane.sv
// ============================================================================
// Module      : parity_lane
// Description : Combinational parity generate/check for a single data lane.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_lane
    import parity_pkg::*;
#(
    parameter int LANE_WIDTH = 8
) (
    input  logic [LANE_WIDTH-1:0] lane_i,
    input  logic                  odd_i,
    input  logic                  chk_en_i,
    input  logic                  rx_par_i,
    output logic                  par_o,
    output logic                  err_o
);

    logic w_xor;
    logic w_odd;

    assign w_xor = lane_xor(MAX_LANE_W'(lane_i), LANE_WIDTH);
    assign w_odd = (odd_i == PAR_ODD);

    // Received parity is correct when data^par equals the mode bit.
    assign par_o = w_xor ^ w_odd;
    assign err_o = chk_en_i & (w_xor ^ rx_par_i ^ w_odd);

endmodule

`default_nettype wire

// File: rtl/parity_stream.sv
// ============================================================================
// Module      : parity_stream
// Description : One-stage valid/ready pipeline that generates/checks per-lane
//               parity and tracks a sticky error flag and error-beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_stream
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  odd,
    input  logic                  chk_en,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [LANES-1:0]      s_par,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LANES-1:0]      m_par,
    output logic [LANES-1:0]      m_err,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int LANE_WIDTH = DATA_WIDTH / LANES;

    if (!cfg_ok(DATA_WIDTH, LANES)) begin : g_cfg_fatal
        $fatal(1, "parity_stream: DATA_WIDTH must be a nonzero multiple of LANES");
    end

    logic [LANES-1:0]      w_par;
    logic [LANES-1:0]      w_err;
    logic                  w_accept;
    logic                  w_err_beat;

    logic                  m_valid_q,    m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q,     m_data_d;
    logic [LANES-1:0]      m_par_q,      m_par_d;
    logic [LANES-1:0]      m_err_q,      m_err_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q,    err_cnt_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        parity_lane #(
            .LANE_WIDTH (LANE_WIDTH)
        ) u_lane (
            .lane_i   (s_data[g*LANE_WIDTH +: LANE_WIDTH]),
            .odd_i    (odd),
            .chk_en_i (chk_en),
            .rx_par_i (s_par[g]),
            .par_o    (w_par[g]),
            .err_o    (w_err[g])
        );
    end

    // m_ready -> s_ready is the only combinational path through the block.
    assign s_ready    = !rst && (!m_valid_q || m_ready);
    assign w_accept   = s_valid && s_ready;
    assign w_err_beat = w_accept && (|w_err);

    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_par_d      = m_par_q;
        m_err_d      = m_err_q;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;

        if (w_accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_par_d   = w_par;
            m_err_d   = w_err;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        // A clear coinciding with an error beat keeps that beat's event.
        if (clr) begin
            err_sticky_d = w_err_beat;
            err_cnt_d    = w_err_beat ? CNT_WIDTH'(1) : '0;
        end else if (w_err_beat) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_par_q      <= '0;
            m_err_q      <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_par_q      <= m_par_d;
            m_err_q      <= m_err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_par      = m_par_q;
    assign m_err      = m_err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_parity_stream.sv
// ============================================================================
// Module      : tb_parity_stream
// Description : Scoreboard bench for parity_stream (16-bit data, 2 lanes,
//               2-bit error counter) driven by hand-computed directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_stream;
    import parity_pkg::*;

    localparam int DW = 16;
    localparam int NL = 2;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NL-1:0] par;
        logic [NL-1:0] err;
        logic [CW-1:0] cnt;
        logic          sticky;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          odd;
    logic          chk_en;
    logic          clr;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [NL-1:0] s_par;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [NL-1:0] m_par;
    logic [NL-1:0] m_err;
    logic          err_sticky;
    logic [CW-1:0] err_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    parity_stream #(
        .DATA_WIDTH (DW),
        .LANES      (NL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .odd        (odd),
        .chk_en     (chk_en),
        .clr        (clr),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_par      (s_par),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_par      (m_par),
        .m_err      (m_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, between handshakes.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_beat: got m_data %0h with no beat expected at %0t", m_data, $time);
            end else begin
                check("m_data",     32'(m_data),     32'(q[0].data));
                check("m_par",      32'(m_par),      32'(q[0].par));
                check("m_err",      32'(m_err),      32'(q[0].err));
                check("err_cnt",    32'(err_cnt),    32'(q[0].cnt));
                check("err_sticky", 32'(err_sticky), 32'(q[0].sticky));
                if (!m_ready) begin
                    check("s_ready_stall", 32'(s_ready), 32'd0);
                end else begin
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [NL-1:0] p,
                        input logic o, input logic c, input logic cl,
                        input logic [NL-1:0] ep, input logic [NL-1:0] ee,
                        input logic [CW-1:0] ec, input logic es);
        int n;
        exp_t e;
        n       = 0;
        s_data  = d;
        s_par   = p;
        odd     = o;
        chk_en  = c;
        clr     = cl;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: s_ready stayed 0 for data %0h", d);
        end else begin
            @(posedge clk);
            e.data   = d;
            e.par    = ep;
            e.err    = ee;
            e.cnt    = ec;
            e.sticky = es;
            q.push_back(e);
        end
        #1;
        s_valid = 1'b0;
        clr     = 1'b0;
        s_data  = '0;
        s_par   = '0;
    endtask

    task automatic clear_only();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_cnt",    32'(err_cnt),    32'd0);
        check("clr_sticky", 32'(err_sticky), 32'd0);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        odd     = PAR_EVEN;
        chk_en  = 1'b0;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_par   = '0;
        m_ready = 1'b1;

        // Reset held for two cycles.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_m_valid",    32'(m_valid),    32'd0);
            check("rst_err_cnt",    32'(err_cnt),    32'd0);
            check("rst_err_sticky", 32'(err_sticky), 32'd0);
            check("rst_s_ready",    32'(s_ready),    32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Generate only: lane0=0x03 (even ones), lane1=0x01 (odd ones).
        send(16'h0103, 2'b00, PAR_EVEN, 1'b0, 1'b0, 2'b10, 2'b00, 2'd0, 1'b0);
        send(16'h0103, 2'b11, PAR_ODD,  1'b0, 1'b0, 2'b01, 2'b00, 2'd0, 1'b0);

        // Check mode: wrong lane1 parity, then correct parity.
        send(16'h0103, 2'b00, PAR_EVEN, 1'b1, 1'b0, 2'b10, 2'b10, 2'd1, 1'b1);
        send(16'h0103, 2'b10, PAR_EVEN, 1'b1, 1'b0, 2'b10, 2'b00, 2'd1, 1'b1);

        // Backpressure: first error beat held three cycles, second waits.
        clear_only();
        m_ready = 1'b0;
        send(16'h0103, 2'b00, PAR_EVEN, 1'b1, 1'b0, 2'b10, 2'b10, 2'd1, 1'b1);
        fork
            send(16'h0003, 2'b01, PAR_EVEN, 1'b1, 1'b0, 2'b00, 2'b01, 2'd2, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join

        // Saturation: lane0=0xFE (odd ones), lane1=0xFF (even ones), odd mode.
        clear_only();
        send(16'hFFFE, 2'b11, PAR_ODD, 1'b1, 1'b0, 2'b10, 2'b01, 2'd1, 1'b1);
        send(16'hFFFE, 2'b11, PAR_ODD, 1'b1, 1'b0, 2'b10, 2'b01, 2'd2, 1'b1);
        send(16'hFFFE, 2'b11, PAR_ODD, 1'b1, 1'b0, 2'b10, 2'b01, 2'd3, 1'b1);
        send(16'hFFFE, 2'b11, PAR_ODD, 1'b1, 1'b0, 2'b10, 2'b01, 2'd3, 1'b1);
        send(16'hFFFE, 2'b11, PAR_ODD, 1'b1, 1'b0, 2'b10, 2'b01, 2'd3, 1'b1);
        send(16'h0103, 2'b01, PAR_ODD, 1'b1, 1'b0, 2'b01, 2'b00, 2'd3, 1'b1);

        // Clear coinciding with an error beat, then clear alone.
        send(16'h0103, 2'b00, PAR_EVEN, 1'b1, 1'b1, 2'b10, 2'b10, 2'd1, 1'b1);
        clear_only();

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
